// File: rtl/imem_pkg.sv
// imem_pkg: shared widths and loader state encoding for the instruction store
package imem_pkg;
  localparam int DATA_W = 9;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} loader_state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: valid/ready write stream carrying instruction words into the loader
interface imem_loader_if;
  import imem_pkg::*;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              wr_ready;
  modport master (output wr_valid, wr_data, wr_last, input wr_ready);
  modport slave (input wr_valid, wr_data, wr_last, output wr_ready);
endinterface

// File: rtl/imem_ram.sv
// imem_ram: simple dual-port RAM, one write port and one registered read port
module imem_ram #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  // write when enabled, read the addressed word every cycle
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: reloadable program store with a streaming write side and a wrapping fetch side
module imem_loader
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_start,
  imem_loader_if.slave      wr,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              loaded,
  output logic [ADDR_W:0]   word_count,
  output logic              trunc
);
  loader_state_t     state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [DATA_W-1:0] rdata;
  logic              rd_ok;
  logic              xfer;
  logic              wrap;
  assign wr.wr_ready = state == LOAD;
  assign xfer = wr.wr_valid && wr.wr_ready;
  assign wrap = {1'b0, fetch_addr} == word_count - (ADDR_W+1)'(1);
  // rd_ok marks that rdata holds a read issued while running, so stale or pre-load data never leaks out
  assign fetch_data = rd_ok ? rdata : '0;
  imem_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (xfer),
    .waddr (wr_ptr),
    .wdata (wr.wr_data),
    .raddr (fetch_addr),
    .rdata (rdata)
  );
  // loader FSM: idle until load_start, accept words until wr_last or full, then serve fetches
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      word_count <= '0;
      trunc      <= 1'b0;
      loaded     <= 1'b0;
      fetch_addr <= '0;
      rd_ok      <= 1'b0;
    end else begin
      rd_ok <= state == RUN && !load_start;
      case (state)
        IDLE: if (load_start) begin
          state      <= LOAD;
          wr_ptr     <= '0;
          word_count <= '0;
          trunc      <= 1'b0;
        end
        LOAD: if (xfer) begin
          wr_ptr     <= wr_ptr + ADDR_W'(1);
          word_count <= word_count + (ADDR_W+1)'(1);
          if (wr.wr_last || wr_ptr == ADDR_W'(DEPTH-1)) begin
            state      <= RUN;
            loaded     <= 1'b1;
            fetch_addr <= '0;
            trunc      <= !wr.wr_last;
          end
        end
        RUN: if (load_start) begin
          state      <= LOAD;
          loaded     <= 1'b0;
          fetch_addr <= '0;
          wr_ptr     <= '0;
          word_count <= '0;
          trunc      <= 1'b0;
        end else if (fetch_en) begin
          fetch_addr <= wrap ? '0 : fetch_addr + ADDR_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
